pht_update_arbiter: RTL

Controller that owns the single-ported pattern history table (PHT) of 2-bit saturating counters and schedules every access to it. It serializes front-end prediction lookups and back-end branch-resolution updates onto the one table port. Updates are buffered in a small FIFO and applied as read-modify-write pairs. After every reset it initializes all entries to weakly-taken. It sits between fetch/branch-resolution logic and the PHT storage array.

---
 rtl/pht_update_arbiter.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/pht_update_arbiter.sv
// Single-port PHT access scheduler: init sweep, lookup reads and buffered read-modify-write updates.
// Optional starvation timer enabled by defining PHT_DRAIN_TIMER_EN.
module pht_update_arbiter #(
    parameter int INDEX_W      = 10,
    parameter int QDEPTH       = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    lookup_valid,
    input  logic [31:0]             lookup_pc,
    output logic                    lookup_ready,
    output logic                    pred_valid,
    output logic                    pred_taken,
    output logic [1:0]              pred_ctr,
    input  logic                    resolve_valid,
    input  logic [31:0]             resolve_pc,
    input  logic                    resolve_taken,
    output logic                    resolve_ready,
    output logic                    tbl_en,
    output logic                    tbl_we,
    output logic [INDEX_W-1:0]      tbl_addr,
    output logic [1:0]              tbl_wdata,
    input  logic [1:0]              tbl_rdata,
    output logic                    init_done,
    output logic [$clog2(QDEPTH):0] q_count,
    output logic [1:0]              state_dbg
);
    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        S_INIT   = 2'd0,
        S_IDLE   = 2'd1,
        S_UPD_WR = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [INDEX_W-1:0] init_addr;
    logic [INDEX_W-1:0] q_idx [QDEPTH];
    logic               q_tkn [QDEPTH];
    logic [PW-1:0]      head, tail;
    logic [CW-1:0]      count;
    logic               push, pop, upd_rd, lookup_grant, drain_force, timer_expired;
    logic [1:0]         upd_wdata;
    logic               unused_pc_bits;

    assign unused_pc_bits = ^{lookup_pc[31:INDEX_W+2], lookup_pc[1:0],
                              resolve_pc[31:INDEX_W+2], resolve_pc[1:0]};

    // Handshakes: a request transfers on a cycle where valid & ready are both high; ready never waits on valid.
    assign drain_force   = (count != '0) & ((count == CW'(QDEPTH)) | timer_expired);
    assign lookup_ready  = ~RESET & (state == S_IDLE) & ~drain_force;
    assign resolve_ready = ~RESET & init_done & (count < CW'(QDEPTH));
    assign push          = resolve_valid & resolve_ready;
    assign q_count       = count;
    assign state_dbg     = state;
    assign pred_ctr      = pred_valid ? tbl_rdata : 2'b00;
    assign pred_taken    = pred_ctr[1];

    always_comb begin
        if (q_tkn[head]) upd_wdata = (tbl_rdata == 2'b11) ? 2'b11 : tbl_rdata + 2'b01;
        else             upd_wdata = (tbl_rdata == 2'b00) ? 2'b00 : tbl_rdata - 2'b01;
    end

    always_comb begin
        state_nxt    = state;
        tbl_en       = 1'b0;
        tbl_we       = 1'b0;
        tbl_addr     = '0;
        tbl_wdata    = 2'b00;
        lookup_grant = 1'b0;
        upd_rd       = 1'b0;
        pop          = 1'b0;
        case (state)
            S_INIT: begin
                tbl_en    = 1'b1;
                tbl_we    = 1'b1;
                tbl_addr  = init_addr;
                tbl_wdata = 2'b10;
                if (init_addr == '1) state_nxt = S_IDLE;
            end
            S_IDLE: begin
                if (drain_force || (!lookup_valid && count != '0)) begin
                    tbl_en    = 1'b1;
                    tbl_addr  = q_idx[head];
                    upd_rd    = 1'b1;
                    state_nxt = S_UPD_WR;
                end else if (lookup_valid) begin
                    tbl_en       = 1'b1;
                    tbl_addr     = lookup_pc[INDEX_W+1:2];
                    lookup_grant = 1'b1;
                end
            end
            S_UPD_WR: begin
                tbl_en    = 1'b1;
                tbl_we    = 1'b1;
                tbl_addr  = q_idx[head];
                tbl_wdata = upd_wdata;
                pop       = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_INIT;
        endcase
        // Reset suppresses any table access, including a write pending in S_UPD_WR.
        if (RESET) begin
            tbl_en       = 1'b0;
            tbl_we       = 1'b0;
            tbl_addr     = '0;
            tbl_wdata    = 2'b00;
            lookup_grant = 1'b0;
            upd_rd       = 1'b0;
            pop          = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state      <= S_INIT;
            init_addr  <= '0;
            init_done  <= 1'b0;
            pred_valid <= 1'b0;
            head       <= '0;
            tail       <= '0;
            count      <= '0;
        end else begin
            state      <= state_nxt;
            pred_valid <= lookup_grant;
            if (state == S_INIT) init_addr <= init_addr + INDEX_W'(1);
            if (state == S_INIT && state_nxt == S_IDLE) init_done <= 1'b1;
            if (push) tail <= tail + PW'(1);
            if (pop)  head <= head + PW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            q_idx[tail] <= resolve_pc[INDEX_W+1:2];
            q_tkn[tail] <= resolve_taken;
        end
    end

`ifdef PHT_DRAIN_TIMER_EN
    localparam int TW = $clog2(STARVE_LIMIT + 1);
    logic [TW-1:0] starve_cnt;

    assign timer_expired = (starve_cnt >= TW'(STARVE_LIMIT));

    // Counts lookups that jumped ahead of a waiting update.
    always_ff @(posedge CLK) begin
        if (RESET || upd_rd) starve_cnt <= '0;
        else if (lookup_grant && count != '0 && !timer_expired) starve_cnt <= starve_cnt + TW'(1);
    end
`else
    localparam int unused_starve_limit = STARVE_LIMIT;
    assign timer_expired = 1'b0;
`endif

endmodule
